sevensegment_scan: RTL
======================

Name: sevensegment_scan

Overview:
- Upstream feeder for the `sevensegment` hex decoder.
- Holds a multi-digit hex value and time-multiplexes it across a common-anode digit array.
- Each scan slot presents one 4-bit nibble on `nibble`, which goes straight into `sevensegment.in`. At the same time it drives the matching digit select and decimal point.
- New values arrive via valid/ready and are double-buffered. A new value is applied only at a frame boundary, so a displayed frame never mixes old and new digits.

Parameters:
- DIGITS, 8, number of display digits (≥2).
- PRESCALE, 50000, clk cycles each digit stays lit (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- value_data  in  4*DIGITS  hex value; digit i = value_data[4*i+3:4*i]; digit 0 is rightmost.
- value_dp  in  DIGITS  decimal point per digit, 1 = lit.
- value_valid  in  1  producer has a value.
- value_ready  out  1  block accepts a value this cycle.
- nibble  out  4  nibble of the current digit; feeds `sevensegment.in`.
- dp  out  1  decimal point of the current digit, 1 = lit.
- digit_sel_n  out  DIGITS  one-hot-low digit enable; all ones = display dark.

Behaviour:
- Registers:
  - `active`/`active_dp`: displayed value.
  - `shadow`/`shadow_dp`: buffered value.
  - `pending` flag.
  - `cnt`: prescaler, 0..PRESCALE-1.
  - `idx`: digit index, 0..DIGITS-1.
  - `state`: BLANK or SCAN.
- Reset (rst_n=0 at a clk edge) clears all registers to 0 and sets state=BLANK. Outputs after reset: value_ready=1, digit_sel_n=all ones, nibble=0, dp=0.
- Outputs are combinational from registers only (no path from value_* inputs):
  - nibble = active[4*idx+:4]
  - dp = active_dp[idx]
  - digit_sel_n = ~(1<<idx) in SCAN; all ones in BLANK.
- value_ready = !pending. A transfer occurs when value_valid && value_ready at a clk edge. value_data must stay stable while valid && !ready.
- BLANK state:
  - cnt and idx are held at 0.
  - A transfer loads `active` directly, leaves pending=0, and moves to SCAN.
  - The first digit is lit on the next cycle: 1-cycle latency.
- SCAN state:
  - cnt increments every cycle. At PRESCALE-1 it wraps to 0 and idx advances.
  - idx wraps DIGITS-1 → 0.
  - A frame boundary is the cycle where cnt==PRESCALE-1 and idx==DIGITS-1.
  - A transfer in SCAN writes `shadow` and sets pending=1.
  - At a frame boundary with pending=1: active ← shadow, pending ← 0. The new value is shown from digit 0 of the next frame.
- Simultaneous events:
  - Transfer and frame boundary in the same cycle with pending=0: the value goes to `shadow` and pending=1. It is applied at the following frame boundary; it is never applied directly.
  - With pending=1 no transfer is possible (ready=0), so `shadow` is never overwritten before it is applied.
- Back-pressure: worst-case hold of value_ready=0 is DIGITS*PRESCALE cycles.
- Reset mid-scan returns to BLANK and discards both active and pending values.
- BLANK is left only by a transfer. SCAN is left only by reset.
- Width rule: cnt is $clog2(PRESCALE) bits and idx is $clog2(DIGITS) bits. Both compare against their terminal values, so a non-power-of-two DIGITS never indexes past DIGITS-1.

Optional Feature:
- Macro: SEVENSEGMENT_SCAN_LZB_EN (leading-zero blanking).
- With the macro defined:
  - In SCAN, digit idx>0 is blanked (digit_sel_n all ones for that slot) when two conditions hold: active nibbles idx..DIGITS-1 are all 0, and active_dp bits idx..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Scan timing is unchanged; a blanked slot still lasts PRESCALE cycles.
- Without the macro: every digit is lit in SCAN.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4.
- Reset, then no valid for 50 cycles → digit_sel_n=4'b1111, value_ready=1 throughout.
- In BLANK, send 0x1234 with dp=4'b0001 → next cycle digit_sel_n=4'b1110, nibble=4, dp=1. Every 4 cycles the output steps to nibble 3, then 2, then 1, with digit_sel_n 1101, 1011, 0111. Then it wraps to 1110.
- In SCAN at idx=1, send 0xABCD → value_ready=0 from the next cycle. The rest of the frame still shows 0x1234. The first cycle of the next frame shows nibble=0xD; ready=1 again in that same cycle.
- Hold value_valid=1 continuously with a changing value_data → at most one transfer per frame. Each transfer lands at the next frame boundary; no shadow overwrite.
- Set value_valid=1 exactly at the frame-boundary cycle while pending=0 → the value is shown one full frame later (16 cycles), not at the next frame.
- Pull rst_n low mid-frame for 1 cycle → the following cycle shows digit_sel_n=4'b1111 and value_ready=1. With SEVENSEGMENT_SCAN_LZB_EN defined, send 0x0050 with dp=0 → the slots for digits 3 and 2 show digit_sel_n=4'b1111; digits 1 and 0 are lit.

Source files
------------

// File: rtl/sevensegment_scan_if.sv
// Value handshake between a producer and the seven-segment scanner.
// Master drives data/dp/valid; slave answers with ready.
interface sevensegment_scan_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] value_data;
   logic [DIGITS-1:0]   value_dp;
   logic                value_valid;
   logic                value_ready;

   modport master (
      output value_data,
      output value_dp,
      output value_valid,
      input  value_ready
   );

   modport slave (
      input  value_data,
      input  value_dp,
      input  value_valid,
      output value_ready
   );
endinterface

// File: rtl/sevensegment_scan.sv
// Double-buffered hex scanner feeding a seven-segment decoder.
// Define SEVENSEGMENT_SCAN_LZB_EN to blank leading zero digits.
module sevensegment_scan #(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   sevensegment_scan_if.slave  value,
   output logic [3:0]          nibble,
   output logic                dp,
   output logic [DIGITS-1:0]   digit_sel_n
);

   localparam int CW = $clog2(PRESCALE);
   localparam int IW = $clog2(DIGITS);

   typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [4*DIGITS-1:0] active_q, active_d;
   logic [DIGITS-1:0]   active_dp_q, active_dp_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                pending_q, pending_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;

   logic xfer;
   logic cnt_last;
   logic idx_last;
   logic frame_end;
   logic lzb_blank;

   assign xfer      = value.value_valid && !pending_q;
   assign cnt_last  = (cnt_q == CW'(PRESCALE-1));
   assign idx_last  = (idx_q == IW'(DIGITS-1));
   assign frame_end = (state_q == SCAN) && cnt_last && idx_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BLANK:   if (xfer) state_d = SCAN;
         SCAN:    state_d = SCAN;
         default: state_d = BLANK;
      endcase
   end

   always_comb begin
      active_d    = active_q;
      active_dp_d = active_dp_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      cnt_d       = '0;
      idx_d       = '0;
      unique case (1'b1)
         (state_q == BLANK): begin
            if (xfer) begin
               active_d    = value.value_data;
               active_dp_d = value.value_dp;
            end
         end
         default: begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            idx_d = idx_q;
            if (cnt_last)
               idx_d = idx_last ? '0 : idx_q + 1'b1;
            // ready is low while pending, so a swap and a load never collide
            if (frame_end && pending_q) begin
               active_d    = shadow_q;
               active_dp_d = shadow_dp_q;
               pending_d   = 1'b0;
            end
            if (xfer) begin
               shadow_d    = value.value_data;
               shadow_dp_d = value.value_dp;
               pending_d   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q    <= '0;
         active_dp_q <= '0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         pending_q   <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
      end else begin
         active_q    <= active_d;
         active_dp_q <= active_dp_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
      end
   end

`ifdef SEVENSEGMENT_SCAN_LZB_EN
   logic [DIGITS:0] zero_up;

   always_comb begin
      zero_up         = '0;
      zero_up[DIGITS] = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         zero_up[i] = zero_up[i+1]
                   && (active_q[4*i+:4] == 4'h0)
                   && !active_dp_q[i];
      end
      lzb_blank = 1'b0;
      for (int i = 1; i < DIGITS; i++) begin
         if (idx_q == IW'(i))
            lzb_blank = zero_up[i];
      end
   end
`else
   assign lzb_blank = 1'b0;
`endif

   always_comb begin
      digit_sel_n       = '1;
      nibble            = 4'h0;
      dp                = 1'b0;
      value.value_ready = !pending_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nibble = active_q[4*i+:4];
            dp     = active_dp_q[i];
            if ((state_q == SCAN) && !lzb_blank)
               digit_sel_n[i] = 1'b0;
         end
      end
   end

endmodule
